game_sequencer: RTL
===================

# game_sequencer

Round controller and move arbiter for the counter game. Sequences game rounds, shares the single `counter` between two players with round-robin arbitration, and reloads the counter between rounds. Consumes `win_lose` pulses and keeps the match score. Drives `gameover`/`who` in the same encoding `game_state` uses.

## Interface
- `SIZE`, 4, counter width (matches `counter`)
- `MAX_SCORE`, 4, score width; match ends when a score reaches all-ones (15)
- `TIMEOUT`, 32, PLAY cycles without a result before a forced loss (used only with `GAME_SEQ_TIMEOUT_EN`)

- `clk`  in  1  clock, all state on posedge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  begin match from IDLE or OVER
- `seed`  in  SIZE  value loaded into counter at each round start
- `p0_req`, `p1_req`  in  1  player move request
- `p0_ctrl`, `p1_ctrl`  in  2  requested step code (00 +1, 01 +2, 10 −1, 11 −2)
- `p0_gnt`, `p1_gnt`  out  1  move granted this cycle (one-hot or zero)
- `count`  in  SIZE  current counter value
- `winner`, `loser`  in  1  single-cycle result pulses from `win_lose`
- `init_c`  out  1  counter load enable
- `init_l`  out  SIZE  counter load value
- `control`  out  2  counter step code
- `win_score`, `lose_score`  out  MAX_SCORE  round tallies
- `gameover`  out  1  match finished
- `who`  out  2  10 winner side, 01 loser side, 00 none

## Operation
- States: IDLE, LOAD, PLAY, OVER.
- Counter has no enable, so hold is done by reloading it: whenever no move is granted, `init_c`=1 and `init_l`=`count`. In IDLE and LOAD, `init_l`=`seed` instead.
- IDLE: hold at `seed`. On `start` → LOAD.
- LOAD: one cycle; load `seed`, no grants, then → PLAY.
- PLAY arbitration:
  - Exactly one request: grant it.
  - Both request: grant the player not granted last. The pointer favours p0 after reset and updates only on a grant.
  - On grant: `init_c`=0 and `control`=granted player's ctrl.
  - No request: hold.
- PLAY results:
  - `winner` pulse: `win_score`+1.
  - `loser` pulse: `lose_score`+1.
  - Both in the same cycle: winner takes priority; loser is ignored.
  - After a result: → OVER if the incremented score equals all-ones, else → LOAD.
  - Grants are still issued in the result cycle.
- OVER:
  - `gameover`=1; `who`=10 if `win_score` is all-ones, else 01. Counter held, no grants.
  - On `start`: clear scores, `gameover`, and `who`, then → LOAD.
- `winner`/`loser` outside PLAY are ignored. `start` in LOAD/PLAY is ignored.
- `control` is 00 when nothing is granted.

## Timing
- Registered: state, scores, `gameover`, `who`, rr pointer, timeout counter.
- Combinational from state/req/count: grants, `init_c`, `init_l`, `control`.
- Grant and step code appear in the request cycle; `count` changes at the next edge.
- Result pulse at edge N: score updated and state is LOAD/OVER after edge N.
- Reset values: IDLE, scores 0, `gameover` 0, `who` 00, pointer→p0, timeout 0.
  - Reset outputs are combinational: `init_c` 1, `init_l` `seed`, grants 0, `control` 00.
- Reset mid-match: aborts immediately (async), scores lost.
- Scores never wrap, since a score reaching all-ones always ends the match.

## Configuration
- `GAME_SEQ_TIMEOUT_EN` defined:
  - A counter counts PLAY cycles and clears on entering PLAY.
  - When it reaches `TIMEOUT`−1 with no result, that cycle is treated as a `loser` pulse.
  - A real `winner` in the same cycle wins.
- Not defined: no timeout logic; rounds last until a pulse.

## Structure
- `game_pkg`: `SIZE`, `MAX_SCORE`, state enum, `WHO_NONE`/`WHO_WIN`/`WHO_LOSE` constants, step-code constants.
- Sub-module `rr_arbiter2`: two requesters, last-grant pointer, one-hot grant; pointer update enabled by the sequencer only in PLAY.

## Test plan
- Reset, `seed`=5, `start`; p0_req with ctrl 01 every cycle → LOAD 1 cycle then p0_gnt each cycle, `control`=01, `init_c`=0 in PLAY.
- Both request continuously (p0 00, p1 10) → grants alternate p0,p1,p0…; idle cycles give `init_c`=1, `init_l`=`count`.
- `winner` and `loser` pulsed in the same cycle → `win_score` 0→1, `lose_score` unchanged, next state LOAD with `init_l`=`seed`.
- 15 `winner` pulses → `gameover`=1, `who`=10, grants 0; `start` → scores 0, `gameover` 0, LOAD.
- Assert `reset` mid-PLAY with `win_score`=7 → all outputs at reset values that same cycle.
- With `GAME_SEQ_TIMEOUT_EN`, `TIMEOUT`=8, no pulses → after 8 PLAY cycles `lose_score`+1 and → LOAD.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the counter-game round sequencer.
// Widths, FSM states, `who` encoding and step codes live here.
package game_pkg;

  localparam int SIZE      = 4;
  localparam int MAX_SCORE = 4;
  localparam int TIMEOUT   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_OVER
  } state_e;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_WIN  = 2'b10;
  localparam logic [1:0] WHO_LOSE = 2'b01;

  typedef enum logic [1:0] {
    STEP_INC1 = 2'b00,
    STEP_INC2 = 2'b01,
    STEP_DEC1 = 2'b10,
    STEP_DEC2 = 2'b11
  } step_e;

endpackage

// File: rtl/game_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// The pointer moves only when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // prio_q=0: p0 wins a tie; prio_q=1: p1 wins a tie
  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller and move arbiter for the counter game.
// Optional forced-loss timeout: define GAME_SEQ_TIMEOUT_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SIZE      = game_pkg::SIZE,
  parameter int MAX_SCORE = game_pkg::MAX_SCORE
`ifdef GAME_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = game_pkg::TIMEOUT
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIZE-1:0]      seed,
  input  logic                 p0_req,
  input  logic                 p1_req,
  input  logic [1:0]           p0_ctrl,
  input  logic [1:0]           p1_ctrl,
  output logic                 p0_gnt,
  output logic                 p1_gnt,
  input  logic [SIZE-1:0]      count,
  input  logic                 winner,
  input  logic                 loser,
  output logic                 init_c,
  output logic [SIZE-1:0]      init_l,
  output logic [1:0]           control,
  output logic [MAX_SCORE-1:0] win_score,
  output logic [MAX_SCORE-1:0] lose_score,
  output logic                 gameover,
  output logic [1:0]           who
);

  state_e               state_q, state_d;
  logic [MAX_SCORE-1:0] win_q, win_d;
  logic [MAX_SCORE-1:0] lose_q, lose_d;
  logic [MAX_SCORE-1:0] win_inc, lose_inc;
  logic                 go_q, go_d;
  logic [1:0]           who_q, who_d;
  logic [1:0]           gnt;
  logic                 play;
  logic                 to_hit;
  logic                 res_win, res_lose;

  assign play = (state_q == S_PLAY);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (reset),
    .en  (play),
    .req ({p1_req, p0_req}),
    .gnt (gnt)
  );

`ifdef GAME_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] to_q, to_d;

  // Cleared whenever not in PLAY, so it starts at 0 on PLAY entry
  assign to_d   = play ? to_q + TW'(1) : '0;
  assign to_hit = play && (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign res_win  = play & winner;
  assign res_lose = play & ~winner & (loser | to_hit);

  assign p0_gnt     = gnt[0];
  assign p1_gnt     = gnt[1];
  assign win_score  = win_q;
  assign lose_score = lose_q;
  assign gameover   = go_q;
  assign who        = who_q;

  // Counter has no enable: holding means reloading its own value
  always_comb begin
    init_c  = 1'b1;
    init_l  = count;
    control = STEP_INC1;
    unique case (state_q)
      S_IDLE, S_LOAD: init_l = seed;
      S_PLAY: begin
        if (|gnt) begin
          init_c  = 1'b0;
          control = gnt[1] ? p1_ctrl : p0_ctrl;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    lose_d   = lose_q;
    go_d     = go_q;
    who_d    = who_q;
    win_inc  = win_q + 1'b1;
    lose_inc = lose_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_PLAY;
      S_PLAY: begin
        unique case (1'b1)
          res_win: begin
            win_d   = win_inc;
            state_d = S_LOAD;
            if (&win_inc) begin
              state_d = S_OVER;
              go_d    = 1'b1;
              who_d   = WHO_WIN;
            end
          end
          res_lose: begin
            lose_d  = lose_inc;
            state_d = S_LOAD;
            if (&lose_inc) begin
              state_d = S_OVER;
              go_d    = 1'b1;
              who_d   = WHO_LOSE;
            end
          end
          default: ;
        endcase
      end
      S_OVER: begin
        if (start) begin
          win_d   = '0;
          lose_d  = '0;
          go_d    = 1'b0;
          who_d   = WHO_NONE;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      lose_q  <= '0;
      go_q    <= 1'b0;
      who_q   <= WHO_NONE;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      go_q    <= go_d;
      who_q   <= who_d;
    end
  end

endmodule
